mtm_alu_deserializer: RTL and testbench

Serial receiver at the ALU input. Converts the `sin` bit stream (one bit per `clk`) into operands A and B plus the command byte, and flags packet-count and framing errors. Output goes to the ALU core, which runs the CRC check and the operation. The result returns through the output serializer. Uses the same 11-bit packet format as the output path.

---
 rtl/mtm_alu_deserializer.sv | 89 ++++++++
 tb/tb_mtm_alu_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// Serial 11-bit packet receiver: 8 data bytes {B,A} followed by a command byte.
// r_valid pulses the cycle after the command stop bit is sampled; sin is never backpressured.
module mtm_alu_deserializer #(
    parameter int DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic [3:0]  crc_in,
    output logic        r_valid,
    output logic        err_data
);

    localparam int CW = $clog2(DATA_BYTES + 2);
    localparam logic [CW-1:0] CNT_OK  = CW'(DATA_BYTES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_BYTES + 1);

    typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

    state_t          r_state;
    logic            r_type;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [63:0]     r_staging;
    logic [CW-1:0]   r_byte_cnt;
    logic            r_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_type     <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_staging  <= 64'd0;
            r_byte_cnt <= '0;
            r_bad      <= 1'b0;
            A          <= 32'd0;
            B          <= 32'd0;
            op         <= 3'd0;
            crc_in     <= 4'd0;
            r_valid    <= 1'b0;
            err_data   <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            err_data <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!sin) r_state <= TYPE;
                end
                TYPE: begin
                    r_type    <= sin;
                    r_bit_cnt <= 3'd0;
                    r_state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    r_shift   <= {r_shift[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= STOP;
                end
                STOP: begin
                    // A low stop sample is a framing error only, never a new start bit.
                    if (sin) begin
                        if (!r_type) begin
                            r_staging <= {r_staging[55:0], r_shift};
                            if (r_byte_cnt != CNT_MAX) r_byte_cnt <= r_byte_cnt + 1'b1;
                        end else begin
                            A          <= r_staging[31:0];
                            B          <= r_staging[63:32];
                            op         <= r_shift[6:4];
                            crc_in     <= r_shift[3:0];
                            r_valid    <= 1'b1;
                            err_data   <= (r_byte_cnt != CNT_OK) | r_bad;
                            r_byte_cnt <= '0;
                            r_bad      <= 1'b0;
                        end
                    end else begin
                        r_bad <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench: stimulus queues expected results, the monitor checks each r_valid pulse.
module tb_mtm_alu_deserializer;

    logic        clk;
    logic        rst;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic [3:0]  crc_in;
    logic        r_valid;
    logic        err_data;

    mtm_alu_deserializer #(.DATA_BYTES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .A        (A),
        .B        (B),
        .op       (op),
        .crc_in   (crc_in),
        .r_valid  (r_valid),
        .err_data (err_data)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic        err;
        bit          chk_data;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_vld_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every r_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (r_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r_valid actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("op", {61'd0, op}, {61'd0, e.op});
                chk("crc_in", {60'd0, crc_in}, {60'd0, e.crc});
                chk("err_data", {63'd0, err_data}, {63'd0, e.err});
                if (e.chk_data) begin
                    chk("A", {32'd0, A}, {32'd0, e.a});
                    chk("B", {32'd0, B}, {32'd0, e.b});
                end
                if (e.gap != 0) chk("r_valid_gap", 64'(cyc - last_vld_cyc), 64'(e.gap));
            end
            last_vld_cyc = cyc;
        end else if (err_data !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL err_data_without_r_valid actual=%b required=0", err_data);
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, w[i*8 +: 8], 1'b1);
    endtask

    task automatic expect_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                              input logic [3:0] c, input logic e, input bit cd, input int gap);
        exp_t x;
        x.a = a; x.b = b; x.op = o; x.crc = c; x.err = e; x.chk_data = cd; x.gap = gap;
        q.push_back(x);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_A"}, {32'd0, A}, 64'd0);
        chk({tag, "_B"}, {32'd0, B}, 64'd0);
        chk({tag, "_op"}, {61'd0, op}, 64'd0);
        chk({tag, "_crc_in"}, {60'd0, crc_in}, 64'd0);
        chk({tag, "_r_valid"}, {63'd0, r_valid}, 64'd0);
        chk({tag, "_err_data"}, {63'd0, err_data}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        sin = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state with idle line
        idle(20);
        check_outputs_zero("reset");

        // Normal transaction
        expect_res(32'hAABBCCDD, 32'h11223344, 3'b011, 4'hA, 1'b0, 1'b1, 0);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        send_pkt(1'b1, 8'h3A, 1'b1);
        idle(5);

        // Back-to-back transactions, command bit 7 ignored in the first
        expect_res(32'h05060708, 32'h01020304, 3'd4, 4'h5, 1'b0, 1'b1, 0);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send_pkt(1'b1, 8'hC5, 1'b1);
        expect_res(32'h00000001, 32'hFFFFFFFF, 3'd0, 4'h0, 1'b0, 1'b1, 99);
        send_word(32'hFFFFFFFF);
        send_word(32'h00000001);
        send_pkt(1'b1, 8'h00, 1'b1);
        idle(4);

        // Too few data bytes
        expect_res(32'd0, 32'd0, 3'd1, 4'h2, 1'b1, 1'b0, 0);
        send_word(32'h9ABCDEF0);
        send_pkt(1'b1, 8'h12, 1'b1);
        idle(3);

        // Too many data bytes: the first (0x99) falls out of staging
        expect_res(32'h55667788, 32'h11223344, 3'd2, 4'h5, 1'b1, 1'b1, 0);
        send_pkt(1'b0, 8'h99, 1'b1);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_pkt(1'b1, 8'h25, 1'b1);
        idle(3);

        // Framing error on the 3rd data byte, then a clean transaction
        expect_res(32'd0, 32'd0, 3'd3, 4'hA, 1'b1, 1'b0, 0);
        send_pkt(1'b0, 8'hDE, 1'b1);
        send_pkt(1'b0, 8'hAD, 1'b1);
        send_pkt(1'b0, 8'hBE, 1'b0);
        send_pkt(1'b0, 8'hEF, 1'b1);
        send_word(32'h01234567);
        send_pkt(1'b1, 8'h3A, 1'b1);
        expect_res(32'h8BADF00D, 32'hCAFEF00D, 3'd6, 4'h1, 1'b0, 1'b1, 0);
        send_word(32'hCAFEF00D);
        send_word(32'h8BADF00D);
        send_pkt(1'b1, 8'h61, 1'b1);
        idle(3);

        // Command with a bad stop bit: no pulse, next command flagged
        send_word(32'h13579BDF);
        send_word(32'h2468ACE0);
        send_pkt(1'b1, 8'h11, 1'b0);
        expect_res(32'h4B5A6978, 32'h0F1E2D3C, 3'd3, 4'h3, 1'b1, 1'b1, 0);
        send_word(32'h0F1E2D3C);
        send_word(32'h4B5A6978);
        send_pkt(1'b1, 8'h33, 1'b1);
        idle(3);

        // sin stuck low: framing errors only, no pulses
        for (int i = 0; i < 50; i++) send_bit(1'b0);
        idle(15);

        // Reset during the 5th data byte, then a clean transaction
        send_word(32'h76543210);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rst = 1'b0;
        sin = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        check_outputs_zero("midrst");
        idle(5);
        expect_res(32'h12345678, 32'h0BADCAFE, 3'd4, 4'h7, 1'b0, 1'b1, 0);
        send_word(32'h0BADCAFE);
        send_word(32'h12345678);
        send_pkt(1'b1, 8'h47, 1'b1);

        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
